// File: rtl/penalty_shootout_scorer.sv
// Scoring engine for the penalty game: alternating kicks, regulation with early
// decision, capped sudden death, per-kick history and a one-cycle score event.
module penalty_shootout_scorer #(
    parameter int ROUNDS  = 5,
    parameter int MAX_SD  = 5,
    parameter int SCORE_W = 5,
    parameter int RND_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               kick_valid,
    input  logic               kick_side,
    input  logic               kick_goal,
    output logic [SCORE_W-1:0] score_player,
    output logic [SCORE_W-1:0] score_enemy,
    output logic [RND_W-1:0]   round_idx,
    output logic               expect_side,
    output logic               sudden_death,
    output logic [ROUNDS-1:0]  hist_player,
    output logic [ROUNDS-1:0]  hist_enemy,
    output logic               kick_err,
    output logic               score_evt,
    output logic               match_end,
    output logic               match_result,
    output logic               match_draw
);

    typedef enum logic [1:0] {S_IDLE, S_REG, S_SD, S_DONE} state_t;

    // Wide enough to hold score + remaining kicks without overflow.
    localparam int CW = ((SCORE_W > RND_W) ? SCORE_W : RND_W) + 2;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] sp_q, sp_d, se_q, se_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic               expect_q, expect_d;
    logic               sd_q, sd_d;
    logic [ROUNDS-1:0]  hist_p_q, hist_p_d, hist_e_q, hist_e_d;
    logic               kick_err_q, kick_err_d;
    logic               score_evt_q, score_evt_d;
    logic               end_q, end_d;
    logic               result_q, result_d;
    logic               draw_q, draw_d;

    logic [ROUNDS-1:0]  hist_sel;
    logic               playing;
    logic [CW-1:0]      sp_x, se_x, rp_x, re_x;

    genvar gi;
    generate
        for (gi = 0; gi < ROUNDS; gi++) begin : g_hist_sel
            assign hist_sel[gi] = (round_q == RND_W'(gi));
        end
    endgenerate

    assign playing = (state_q == S_REG) || (state_q == S_SD);

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        se_d        = se_q;
        round_d     = round_q;
        expect_d    = expect_q;
        sd_d        = sd_q;
        hist_p_d    = hist_p_q;
        hist_e_d    = hist_e_q;
        kick_err_d  = 1'b0;
        score_evt_d = 1'b0;
        end_d       = end_q;
        result_d    = result_q;
        draw_d      = draw_q;
        sp_x        = '0;
        se_x        = '0;
        rp_x        = '0;
        re_x        = '0;

        if (start) begin
            state_d  = S_REG;
            sp_d     = '0;
            se_d     = '0;
            round_d  = '0;
            expect_d = 1'b0;
            sd_d     = 1'b0;
            hist_p_d = '0;
            hist_e_d = '0;
            end_d    = 1'b0;
            result_d = 1'b0;
            draw_d   = 1'b0;
        end else if (kick_valid && playing) begin
            if (kick_side != expect_q) begin
                kick_err_d = 1'b1;
            end else begin
                score_evt_d = 1'b1;
                expect_d    = ~expect_q;
                if (kick_goal) begin
                    if (kick_side) se_d = se_q + 1'b1;
                    else           sp_d = sp_q + 1'b1;
                end
                if (kick_side) round_d = round_q + 1'b1;

                if (state_q == S_REG) begin
                    if (kick_side) hist_e_d = (hist_e_q & ~hist_sel) | (hist_sel & {ROUNDS{kick_goal}});
                    else           hist_p_d = (hist_p_q & ~hist_sel) | (hist_sel & {ROUNDS{kick_goal}});

                    // Remaining kicks after this one; the player always has one
                    // more kick done than the enemy within the current round.
                    sp_x = CW'(sp_d);
                    se_x = CW'(se_d);
                    rp_x = CW'(ROUNDS) - CW'(round_q) - CW'(1);
                    re_x = CW'(ROUNDS) - CW'(round_q) - {{(CW-1){1'b0}}, kick_side};

                    if (sp_x > se_x + re_x) begin
                        state_d  = S_DONE;
                        end_d    = 1'b1;
                        result_d = 1'b1;
                    end else if (se_x > sp_x + rp_x) begin
                        state_d  = S_DONE;
                        end_d    = 1'b1;
                        result_d = 1'b0;
                    end else if (kick_side && (round_q == RND_W'(ROUNDS - 1))) begin
                        if (MAX_SD == 0) begin
                            state_d = S_DONE;
                            end_d   = 1'b1;
                            draw_d  = 1'b1;
                        end else begin
                            state_d = S_SD;
                            sd_d    = 1'b1;
                        end
                    end
                end else if (kick_side) begin
                    if (sp_d != se_d) begin
                        state_d  = S_DONE;
                        end_d    = 1'b1;
                        result_d = (sp_d > se_d);
                    end else if (round_d == RND_W'(ROUNDS + MAX_SD)) begin
                        state_d = S_DONE;
                        end_d   = 1'b1;
                        draw_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sp_q        <= '0;
            se_q        <= '0;
            round_q     <= '0;
            expect_q    <= 1'b0;
            sd_q        <= 1'b0;
            hist_p_q    <= '0;
            hist_e_q    <= '0;
            kick_err_q  <= 1'b0;
            score_evt_q <= 1'b0;
            end_q       <= 1'b0;
            result_q    <= 1'b0;
            draw_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            se_q        <= se_d;
            round_q     <= round_d;
            expect_q    <= expect_d;
            sd_q        <= sd_d;
            hist_p_q    <= hist_p_d;
            hist_e_q    <= hist_e_d;
            kick_err_q  <= kick_err_d;
            score_evt_q <= score_evt_d;
            end_q       <= end_d;
            result_q    <= result_d;
            draw_q      <= draw_d;
        end
    end

    assign score_player = sp_q;
    assign score_enemy  = se_q;
    assign round_idx    = round_q;
    assign expect_side  = expect_q;
    assign sudden_death = sd_q;
    assign hist_player  = hist_p_q;
    assign hist_enemy   = hist_e_q;
    assign kick_err     = kick_err_q;
    assign score_evt    = score_evt_q;
    assign match_end    = end_q;
    assign match_result = result_q;
    assign match_draw   = draw_q;

endmodule
